box_ctrl: RTL and testbench



---
 rtl/box_ctrl.sv | 117 +++++++++++
 tb/tb_box_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/box_ctrl.sv
// Sequencer/arbiter for the INBOX -> OUTBOX -> UART-TX datapath.
// Serves manual step/send pulses and an auto-run mode with a programmable gap between grants.
module box_ctrl #(
  parameter int              GAP_W    = 24,
  parameter logic [GAP_W-1:0] AUTO_GAP = 24'd1200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_step,
  input  logic       i_send,
  input  logic       i_auto,
  input  logic       i_inbox_empty_n,
  input  logic       i_outbox_full,
  input  logic       i_outbox_empty_n,
  input  logic       i_tx_busy,
  output logic       o_move,
  output logic       o_send,
  output logic [1:0] o_state,
  output logic [7:0] o_moved_cnt,
  output logic [7:0] o_sent_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SEND   = 2'd2,
    TXWAIT = 2'd3
  } state_t;

  localparam logic GRANT_MOVE = 1'b0;
  localparam logic GRANT_SEND = 1'b1;

  state_t           state;
  logic             step_pend;
  logic             send_pend;
  logic             last_grant;
  logic             wait_first;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       moved_cnt;
  logic [7:0]       sent_cnt;

  logic move_ok, send_ok, auto_fire;
  logic move_elig, send_elig;
  logic grant_move, grant_send;
  logic step_clr, send_clr;

  // Handshake: o_move/o_send are one-cycle strobes taken by the FIFOs/TX unconditionally;
  // eligibility (move_ok/send_ok) is the only back-pressure, checked before a grant.
  always_comb begin
    move_ok    = i_inbox_empty_n & ~i_outbox_full;
    send_ok    = i_outbox_empty_n & ~i_tx_busy;
    auto_fire  = i_auto & (gap_cnt == '0);
    move_elig  = (step_pend | auto_fire) & move_ok;
    send_elig  = (send_pend | auto_fire) & send_ok;
    grant_move = 1'b0;
    grant_send = 1'b0;
    if (state == IDLE) begin
      grant_move = move_elig & (~send_elig | (last_grant == GRANT_SEND));
      grant_send = send_elig & ~grant_move;
    end
    // Stale presses in IDLE are dropped rather than deferred.
    step_clr = (state == MOVE) | ((state == IDLE) & ~move_ok);
    send_clr = (state == SEND) | ((state == IDLE) & ~send_ok);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      step_pend  <= 1'b0;
      send_pend  <= 1'b0;
      last_grant <= GRANT_SEND;
      wait_first <= 1'b0;
      gap_cnt    <= '0;
      moved_cnt  <= 8'd0;
      sent_cnt   <= 8'd0;
    end else begin
      step_pend <= i_step | (step_pend & ~step_clr);
      send_pend <= i_send | (send_pend & ~send_clr);

      if (grant_move || grant_send)
        gap_cnt <= AUTO_GAP;
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - {{(GAP_W-1){1'b0}}, 1'b1};

      case (state)
        IDLE: begin
          if (grant_move)      state <= MOVE;
          else if (grant_send) state <= SEND;
        end
        MOVE: begin
          moved_cnt  <= moved_cnt + 8'd1;
          last_grant <= GRANT_MOVE;
          state      <= IDLE;
        end
        SEND: begin
          sent_cnt   <= sent_cnt + 8'd1;
          last_grant <= GRANT_SEND;
          wait_first <= 1'b1;
          state      <= TXWAIT;
        end
        TXWAIT: begin
          // First cycle ignores busy: TX raises it one cycle after the write.
          if (wait_first)      wait_first <= 1'b0;
          else if (!i_tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_move      = (state == MOVE);
  assign o_send      = (state == SEND);
  assign o_state     = state;
  assign o_moved_cnt = moved_cnt;
  assign o_sent_cnt  = sent_cnt;

endmodule

// File: tb/tb_box_ctrl.sv
// Directed bench for box_ctrl: manual step/send, discard of stale presses, TX busy gating,
// auto-run alternation with gap, full-OUTBOX blocking, and reset from TXWAIT.
module tb_box_ctrl;

  logic       clk;
  logic       reset_n;
  logic       i_step, i_send, i_auto;
  logic       i_inbox_empty_n, i_outbox_full, i_outbox_empty_n, i_tx_busy;
  logic       o_move, o_send;
  logic [1:0] o_state;
  logic [7:0] o_moved_cnt, o_sent_cnt;

  int checks   = 0;
  int failures = 0;

  box_ctrl #(.GAP_W(24), .AUTO_GAP(24'd4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_step           (i_step),
    .i_send           (i_send),
    .i_auto           (i_auto),
    .i_inbox_empty_n  (i_inbox_empty_n),
    .i_outbox_full    (i_outbox_full),
    .i_outbox_empty_n (i_outbox_empty_n),
    .i_tx_busy        (i_tx_busy),
    .o_move           (o_move),
    .o_send           (o_send),
    .o_state          (o_state),
    .o_moved_cnt      (o_moved_cnt),
    .o_sent_cnt       (o_sent_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe monitor
  int   cyc = 0;
  int   moves_seen = 0, sends_seen = 0, overlap = 0, doubles = 0;
  logic prev_move = 1'b0, prev_send = 1'b0;
  logic recording = 1'b0;
  int   kind_q[$];
  int   time_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_move) moves_seen++;
    if (o_send) sends_seen++;
    if (o_move && o_send) overlap++;
    if ((o_move && prev_move) || (o_send && prev_send)) doubles++;
    prev_move = o_move;
    prev_send = o_send;
    if (recording && (o_move || o_send)) begin
      kind_q.push_back(o_move ? 0 : 1);
      time_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    i_step = 1'b1;
    tick(1);
    i_step = 1'b0;
  endtask

  task automatic pulse_send();
    i_send = 1'b1;
    tick(1);
    i_send = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int base_m, base_s;

  initial begin
    reset_n = 1'b0; i_step = 1'b0; i_send = 1'b0; i_auto = 1'b0;
    i_inbox_empty_n = 1'b1; i_outbox_full = 1'b0; i_outbox_empty_n = 1'b0; i_tx_busy = 1'b0;
    tick(2);
    check("rst_state", o_state, 0);
    check("rst_move", o_move, 0);
    check("rst_send", o_send, 0);
    check("rst_moved_cnt", o_moved_cnt, 0);
    check("rst_sent_cnt", o_sent_cnt, 0);
    reset_n = 1'b1;
    tick(2);

    // three manual moves, first one checked for +2 latency
    base_m = moves_seen; base_s = sends_seen;
    pulse_step();
    check("lat_plus1_move", o_move, 0);
    tick(1);
    check("lat_plus2_move", o_move, 1);
    check("lat_plus2_state", o_state, 1);
    tick(1);
    check("move_one_cycle", o_move, 0);
    check("moved_cnt_1", o_moved_cnt, 1);
    tick(8);
    pulse_step();
    tick(9);
    pulse_step();
    tick(9);
    check("moves_3", moves_seen - base_m, 3);
    check("moved_cnt_3", o_moved_cnt, 3);
    check("no_send_t1", sends_seen - base_s, 0);

    // press on empty INBOX is discarded, not deferred
    i_inbox_empty_n = 1'b0;
    base_m = moves_seen;
    pulse_step();
    tick(5);
    check("empty_no_move", moves_seen - base_m, 0);
    i_inbox_empty_n = 1'b1;
    tick(6);
    check("refill_no_move", moves_seen - base_m, 0);
    check("refill_idle", o_state, 0);

    // send gated by TX busy
    i_outbox_empty_n = 1'b1;
    base_s = sends_seen;
    pulse_send();
    tick(1);
    check("send_strobe", o_send, 1);
    check("send_state", o_state, 2);
    tick(1);
    i_tx_busy = 1'b1;
    check("txwait_state", o_state, 3);
    tick(4);
    pulse_send();
    tick(1000);
    check("busy_one_send", sends_seen - base_s, 1);
    check("busy_txwait", o_state, 3);
    tick(34);
    i_tx_busy = 1'b0;
    tick(1);
    check("busy_fall_idle", o_state, 0);
    tick(1);
    check("second_send", o_send, 1);
    tick(4);
    check("sends_2", sends_seen - base_s, 2);
    check("sent_cnt_2", o_sent_cnt, 2);

    // auto-run alternation, gap 4
    recording = 1'b1;
    i_auto = 1'b1;
    tick(30);
    recording = 1'b0;
    check("auto_grants_ge4", kind_q.size() >= 4, 1);
    if (kind_q.size() >= 4) begin
      check("auto_first_move", kind_q[0], 0);
      for (int i = 1; i < 4; i++) begin
        check("auto_alternate", kind_q[i], (kind_q[i-1] == 0) ? 1 : 0);
        check("auto_gap_ge4", (time_q[i] - time_q[i-1]) >= 4, 1);
      end
    end

    // full OUTBOX blocks moves, sends continue
    i_outbox_full = 1'b1;
    tick(1);
    base_m = moves_seen; base_s = sends_seen;
    pulse_step();
    tick(40);
    check("full_no_move", moves_seen - base_m, 0);
    check("full_sends_go", (sends_seen - base_s) >= 2, 1);
    i_outbox_full = 1'b0;
    tick(30);
    check("unfull_moves", (moves_seen - base_m) >= 1, 1);
    i_auto = 1'b0;
    tick(10);

    // reset from TXWAIT with sent_cnt = 7
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    for (int k = 0; k < 6; k++) begin
      pulse_send();
      tick(5);
    end
    pulse_send();
    tick(1);
    i_tx_busy = 1'b1;
    tick(1);
    check("pre_rst_txwait", o_state, 3);
    check("pre_rst_sent7", o_sent_cnt, 7);
    i_step = 1'b1; i_send = 1'b1;
    tick(1);
    i_step = 1'b0; i_send = 1'b0;
    reset_n = 1'b0;
    tick(1);
    check("mid_rst_state", o_state, 0);
    check("mid_rst_sent", o_sent_cnt, 0);
    check("mid_rst_moved", o_moved_cnt, 0);
    check("mid_rst_strobes", {o_move, o_send}, 0);
    reset_n = 1'b1;
    i_tx_busy = 1'b0;
    base_m = moves_seen; base_s = sends_seen;
    tick(6);
    check("rst_pend_cleared", (moves_seen - base_m) + (sends_seen - base_s), 0);

    check("never_overlap", overlap, 0);
    check("one_cycle_strobes", doubles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
